// File: rtl/wb_bfm_pkg.sv
// rtl/wb_bfm_pkg.sv - shared Wishbone B3 constants, checker state encoding and code priority helper
// Purpose: CTI/BTE encodings, violation codes 1-8, FSM states and the lowest-code-wins
//          priority picker shared by the protocol checker and the BFM memory model.
// Ports:   none (package).
package wb_bfm_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_CONST   = 3'b001;
  localparam logic [2:0] CTI_INC     = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam logic [1:0] BTE_LINEAR  = 2'b00;
  localparam logic [1:0] BTE_WRAP4   = 2'b01;
  localparam logic [1:0] BTE_WRAP8   = 2'b10;
  localparam logic [1:0] BTE_WRAP16  = 2'b11;

  localparam logic [3:0] CODE_NONE       = 4'd0;
  localparam logic [3:0] CODE_STB_NO_CYC = 4'd1;
  localparam logic [3:0] CODE_MULTI_RESP = 4'd2;
  localparam logic [3:0] CODE_SPURIOUS   = 4'd3;
  localparam logic [3:0] CODE_UNSTABLE   = 4'd4;
  localparam logic [3:0] CODE_BURST_ADR  = 4'd5;
  localparam logic [3:0] CODE_BURST_CTI  = 4'd6;
  localparam logic [3:0] CODE_TIMEOUT    = 4'd7;
  localparam logic [3:0] CODE_CYC_DROP   = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CYCLE = 2'd1,
    ST_BURST = 2'd2
  } state_t;

  // Bit i of viol set means code i fired this cycle; the lowest index wins.
  function automatic logic [3:0] first_code(input logic [8:1] viol);
    logic [3:0] code;
    code = CODE_NONE;
    for (int i = 8; i >= 1; i--) begin
      if (viol[i]) code = 4'(i);
    end
    return code;
  endfunction

endpackage

// File: rtl/wb_bfm_checker_if.sv
// rtl/wb_bfm_checker_if.sv - Wishbone B3 master-to-slave bus bundle
// Purpose: groups the bus signals shared by BFM transactor, memory model and checker.
// Modports: master (drives request, sees response), slave (sees request, drives response),
//           monitor (observes everything, drives nothing).
interface wb_bfm_checker_if #(
  parameter int aw = 32,
  parameter int dw = 32
);
  logic [aw-1:0]   adr;
  logic [dw-1:0]   dat;
  logic [dw/8-1:0] sel;
  logic            we;
  logic            cyc;
  logic            stb;
  logic [2:0]      cti;
  logic [1:0]      bte;
  logic            ack;
  logic            err;
  logic            rty;

  modport master  (output adr, dat, sel, we, cyc, stb, cti, bte, input ack, err, rty);
  modport slave   (input adr, dat, sel, we, cyc, stb, cti, bte, output ack, err, rty);
  modport monitor (input adr, dat, sel, we, cyc, stb, cti, bte, ack, err, rty);
endinterface

// File: rtl/wb_bfm_burst_adr.sv
// rtl/wb_bfm_burst_adr.sv - expected next beat address for linear and wrapping bursts
// Purpose: combinational next-address calculation, also used by the BFM memory model.
// Ports:   adr (current beat address), bte (burst type), next_adr (address of following beat).
module wb_bfm_burst_adr
  import wb_bfm_pkg::*;
#(
  parameter int aw = 32,
  parameter int dw = 32
) (
  input  logic [aw-1:0] adr,
  input  logic [1:0]    bte,
  output logic [aw-1:0] next_adr
);
  localparam int bw = dw / 8;

  logic [aw-1:0] incr;
  logic [aw-1:0] mask;

  assign incr = adr + aw'(bw);

  // Wrap window is beats*bytes_per_beat; bits inside it increment, bits above stay fixed.
  always_comb begin
    mask = '0;
    case (bte)
      BTE_WRAP4:  mask = aw'(4 * bw - 1);
      BTE_WRAP8:  mask = aw'(8 * bw - 1);
      BTE_WRAP16: mask = aw'(16 * bw - 1);
      default:    mask = '0;
    endcase
  end

  assign next_adr = (bte == BTE_LINEAR) ? incr : ((adr & ~mask) | (incr & mask));
endmodule

// File: rtl/wb_bfm_checker.sv
// rtl/wb_bfm_checker.sv - passive Wishbone B3 protocol checker with transaction/beat counters
// Purpose: tracks classic and incrementing-burst cycles, flags the first protocol violation
//          (sticky code), counts violating cycles, completed cyc periods and terminated beats.
// Ports:   wb_clk_i, wb_rst_i (async active-high), wb (monitor modport, never driven),
//          chk_err_o, chk_code_o, chk_err_cnt_o, chk_txn_cnt_o, chk_beat_cnt_o, chk_burst_o.
// Option:  WB_BFM_CHECKER_TIMEOUT_EN adds the response timeout counter (code 7).
module wb_bfm_checker
  import wb_bfm_pkg::*;
#(
  parameter int aw      = 32,
  parameter int dw      = 32,
  parameter int TIMEOUT = 256
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  wb_bfm_checker_if.monitor    wb,
  output logic                 chk_err_o,
  output logic [3:0]           chk_code_o,
  output logic [15:0]          chk_err_cnt_o,
  output logic [31:0]          chk_txn_cnt_o,
  output logic [31:0]          chk_beat_cnt_o,
  output logic                 chk_burst_o
);
  state_t state_q, state_d;

  logic            resp, strobe, term, multi, tmo_hit;
  logic [8:1]      viol;
  logic [3:0]      code;
  logic [aw-1:0]   next_adr, exp_adr_q, adr_q;
  logic [dw-1:0]   dat_q;
  logic [dw/8-1:0] sel_q;
  logic            we_q, pend_q;
  logic [2:0]      cti_q;
  logic [1:0]      bte_q, beat_bte_q;

  assign resp   = wb.ack | wb.err | wb.rty;
  assign strobe = wb.stb & wb.cyc;
  assign term   = strobe & resp;
  assign multi  = (wb.ack & wb.err) | (wb.ack & wb.rty) | (wb.err & wb.rty);

  wb_bfm_burst_adr #(.aw(aw), .dw(dw)) u_burst_adr (
    .adr      (wb.adr),
    .bte      (wb.bte),
    .next_adr (next_adr)
  );

`ifdef WB_BFM_CHECKER_TIMEOUT_EN
  localparam int tw = $clog2(TIMEOUT + 1);
  logic [tw-1:0] tmo_q;

  // Saturates at TIMEOUT so the violation fires exactly once per stuck strobe.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i)                 tmo_q <= '0;
    else if (!wb.stb || term)     tmo_q <= '0;
    else if (tmo_q != tw'(TIMEOUT)) tmo_q <= tmo_q + 1'b1;
  end

  assign tmo_hit = wb.stb & ~term & (tmo_q == tw'(TIMEOUT - 1));
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign tmo_hit        = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    if (!wb.cyc) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_CYCLE:
          state_d = (term && wb.ack && wb.cti == CTI_INC) ? ST_BURST : ST_CYCLE;
        ST_BURST:
          if (term && (wb.err || wb.rty || (wb.ack && wb.cti == CTI_EOB))) state_d = ST_CYCLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    viol = '0;
    viol[CODE_STB_NO_CYC] = wb.stb & ~wb.cyc;
    viol[CODE_MULTI_RESP] = multi;
    viol[CODE_SPURIOUS]   = resp & ~strobe;
    // History is only meaningful when the previous cycle held an unanswered strobe.
    viol[CODE_UNSTABLE]   = pend_q & ((wb.adr != adr_q) | (wb.we != we_q) | (wb.sel != sel_q) |
                                      (wb.cti != cti_q) | (wb.bte != bte_q) |
                                      (we_q & (wb.dat != dat_q)));
    viol[CODE_BURST_ADR]  = (state_q == ST_BURST) & term & (wb.adr != exp_adr_q);
    viol[CODE_BURST_CTI]  = (state_q == ST_BURST) & term &
                            (((wb.cti != CTI_INC) & (wb.cti != CTI_EOB)) | (wb.bte != beat_bte_q));
    viol[CODE_TIMEOUT]    = tmo_hit;
    viol[CODE_CYC_DROP]   = pend_q & ~wb.cyc;
  end

  assign code = first_code(viol);

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      adr_q          <= '0;
      dat_q          <= '0;
      sel_q          <= '0;
      we_q           <= 1'b0;
      cti_q          <= '0;
      bte_q          <= '0;
      pend_q         <= 1'b0;
      exp_adr_q      <= '0;
      beat_bte_q     <= '0;
      chk_err_o      <= 1'b0;
      chk_code_o     <= '0;
      chk_err_cnt_o  <= '0;
      chk_txn_cnt_o  <= '0;
      chk_beat_cnt_o <= '0;
    end else begin
      adr_q  <= wb.adr;
      dat_q  <= wb.dat;
      sel_q  <= wb.sel;
      we_q   <= wb.we;
      cti_q  <= wb.cti;
      bte_q  <= wb.bte;
      pend_q <= strobe & ~resp;
      if (term) begin
        exp_adr_q  <= next_adr;
        beat_bte_q <= wb.bte;
        if (chk_beat_cnt_o != '1) chk_beat_cnt_o <= chk_beat_cnt_o + 32'd1;
      end
      if (!wb.cyc && state_q != ST_IDLE && chk_txn_cnt_o != '1)
        chk_txn_cnt_o <= chk_txn_cnt_o + 32'd1;
      if (|viol) begin
        if (!chk_err_o) begin
          chk_err_o  <= 1'b1;
          chk_code_o <= code;
        end
        if (chk_err_cnt_o != 16'hFFFF) chk_err_cnt_o <= chk_err_cnt_o + 16'd1;
      end
    end
  end

  assign chk_burst_o = (state_q == ST_BURST);
endmodule

// File: tb/tb_wb_bfm_checker.sv
// tb/tb_wb_bfm_checker.sv - self-checking bench for wb_bfm_checker with a rule-level reference model
module tb_wb_bfm_checker;
  localparam int aw  = 32;
  localparam int dw  = 32;
  localparam int bw  = dw / 8;
  localparam int tmo = 8;
`ifdef WB_BFM_CHECKER_TIMEOUT_EN
  localparam bit tmo_en = 1'b1;
`else
  localparam bit tmo_en = 1'b0;
`endif

  typedef struct packed {
    bit        cyc, stb, we, ack, err, rty;
    bit [31:0] adr, dat;
    bit [3:0]  sel;
    bit [2:0]  cti;
    bit [1:0]  bte;
  } bus_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_bfm_checker_if #(.aw(aw), .dw(dw)) wb ();

  logic        chk_err, chk_burst;
  logic [3:0]  chk_code;
  logic [15:0] chk_err_cnt;
  logic [31:0] chk_txn_cnt, chk_beat_cnt;

  wb_bfm_checker #(.aw(aw), .dw(dw), .TIMEOUT(tmo)) dut (
    .wb_clk_i       (clk),
    .wb_rst_i       (rst),
    .wb             (wb),
    .chk_err_o      (chk_err),
    .chk_code_o     (chk_code),
    .chk_err_cnt_o  (chk_err_cnt),
    .chk_txn_cnt_o  (chk_txn_cnt),
    .chk_beat_cnt_o (chk_beat_cnt),
    .chk_burst_o    (chk_burst)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model state: what the protocol rules say the checker has seen so far.
  bus_t      cur, m_prev;
  bit        m_in_txn, m_in_burst, m_prev_pend, m_err;
  bit [31:0] m_exp;
  bit [1:0]  m_bte;
  int        m_wait, m_code, m_ecnt, m_txn, m_beats;

  function automatic bit [31:0] next_beat(input bit [31:0] a, input bit [1:0] bte);
    int unsigned span;
    span = (bte == 2'b00) ? 0 : (bw << (int'(bte) + 1));
    if (span == 0) return a + bw;
    return (a - (a % span)) + ((a + bw) % span);
  endfunction

  task automatic model_reset();
    m_prev = '0; m_in_txn = 0; m_in_burst = 0; m_prev_pend = 0; m_err = 0;
    m_exp = '0; m_bte = '0; m_wait = 0; m_code = 0; m_ecnt = 0; m_txn = 0; m_beats = 0;
  endtask

  task automatic model_step();
    int nresp, code;
    bit strobe, beat, moved;
    nresp  = int'(cur.ack) + int'(cur.err) + int'(cur.rty);
    strobe = cur.stb && cur.cyc;
    beat   = strobe && nresp > 0;
    moved  = cur.adr != m_prev.adr || cur.we != m_prev.we || cur.sel != m_prev.sel ||
             cur.cti != m_prev.cti || cur.bte != m_prev.bte || (m_prev.we && cur.dat != m_prev.dat);
    code = 0;
    if (cur.stb && !cur.cyc)                                     code = 1;
    else if (nresp > 1)                                          code = 2;
    else if (nresp > 0 && !strobe)                               code = 3;
    else if (m_prev_pend && moved)                               code = 4;
    else if (m_in_burst && beat && cur.adr != m_exp)             code = 5;
    else if (m_in_burst && beat && ((cur.cti != 3'd2 && cur.cti != 3'd7) || cur.bte != m_bte)) code = 6;
    else if (tmo_en && cur.stb && !beat && m_wait + 1 == tmo)    code = 7;
    else if (m_prev_pend && !cur.cyc)                            code = 8;
    if (code != 0) begin
      if (!m_err) begin m_err = 1; m_code = code; end
      if (m_ecnt < 65535) m_ecnt++;
    end
    if (!cur.cyc) begin
      if (m_in_txn) m_txn++;
      m_in_txn = 0; m_in_burst = 0;
    end else begin
      m_in_txn = 1;
      if (beat) begin
        if (!m_in_burst && cur.ack && cur.cti == 3'd2) m_in_burst = 1;
        else if (m_in_burst && ((cur.ack && cur.cti == 3'd7) || cur.err || cur.rty)) m_in_burst = 0;
      end
    end
    if (beat) begin
      m_beats++;
      m_exp = next_beat(cur.adr, cur.bte);
      m_bte = cur.bte;
    end
    m_wait      = (!cur.stb || beat) ? 0 : m_wait + 1;
    m_prev_pend = strobe && nresp == 0;
    m_prev      = cur;
  endtask

  task automatic apply_bus();
    wb.cyc = cur.cyc; wb.stb = cur.stb; wb.we = cur.we; wb.ack = cur.ack; wb.err = cur.err;
    wb.rty = cur.rty; wb.adr = cur.adr; wb.dat = cur.dat; wb.sel = cur.sel; wb.cti = cur.cti;
    wb.bte = cur.bte;
  endtask

  task automatic tick();
    apply_bus();
    model_step();
    @(posedge clk);
    #1;
    check_eq("err",   32'(chk_err),     32'(m_err));
    check_eq("code",  32'(chk_code),    32'(m_code));
    check_eq("ecnt",  32'(chk_err_cnt), 32'(m_ecnt));
    check_eq("txn",   chk_txn_cnt,      32'(m_txn));
    check_eq("beat",  chk_beat_cnt,     32'(m_beats));
    check_eq("burst", 32'(chk_burst),   32'(m_in_burst));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check_eq("rst_err",   32'(chk_err),     0);
    check_eq("rst_code",  32'(chk_code),    0);
    check_eq("rst_ecnt",  32'(chk_err_cnt), 0);
    check_eq("rst_txn",   chk_txn_cnt,      0);
    check_eq("rst_beat",  chk_beat_cnt,     0);
    check_eq("rst_burst", 32'(chk_burst),   0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic bus_beat(input bit [31:0] a, input bit [2:0] cti, input bit [1:0] bte, input int waits);
    cur.cyc = 1; cur.stb = 1; cur.adr = a; cur.cti = cti; cur.bte = bte;
    cur.ack = 0; cur.err = 0; cur.rty = 0;
    repeat (waits) tick();
    cur.ack = 1;
    tick();
    cur.ack = 0;
  endtask

  task automatic idle_tick();
    cur = '0;
    tick();
  endtask

  task automatic run_burst(input bit [31:0] second_adr);
    bit [31:0] adrs [4];
    bit        exp_b [4];
    adrs  = '{32'h1C, second_adr, 32'h14, 32'h18};
    exp_b = '{1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      bus_beat(adrs[i], (i == 3) ? 3'b111 : 3'b010, 2'b01, 0);
      check_eq("burst_flag", 32'(chk_burst), 32'(exp_b[i]));
      if (second_adr != 32'h10) begin
        check_eq("badadr_err", 32'(chk_err), (i == 0) ? 0 : 1);
        if (i == 1) check_eq("badadr_code", 32'(chk_code), 5);
      end
    end
    idle_tick();
  endtask

  task automatic rand_txn();
    int        kind, nb, waits, r;
    bit [1:0]  bte;
    bit [31:0] a;
    bit        is_burst;
    kind = $urandom_range(0, 9);
    cur = '0;
    if (kind == 0) begin cur.ack = 1; tick(); idle_tick(); return; end
    if (kind == 1) begin cur.stb = 1; tick(); idle_tick(); return; end
    if (kind == 2) begin cur.cyc = 1; cur.stb = 1; tick(); idle_tick(); return; end
    is_burst = kind >= 6;
    bte      = is_burst ? 2'($urandom_range(0, 3)) : 2'b00;
    nb       = !is_burst ? 1 : (bte == 2'b00) ? $urandom_range(2, 5) : (2 << bte);
    a        = $urandom & 32'hFFFF_FFFC;
    cur.cyc  = 1; cur.we = 1'($urandom); cur.sel = 4'($urandom); cur.bte = bte;
    for (int i = 0; i < nb; i++) begin
      cur.stb = 1;
      cur.adr = (is_burst && i == 1 && $urandom_range(0, 7) == 0) ? (a ^ 32'h40) : a;
      cur.dat = $urandom;
      cur.cti = !is_burst ? 3'b000 : (i == nb - 1) ? 3'b111 : 3'b010;
      waits   = $urandom_range(0, 2);
      for (int w = 0; w < waits; w++) begin
        if ($urandom_range(0, 15) == 0) cur.adr ^= 32'h4;
        tick();
      end
      r = $urandom_range(0, 19);
      cur.ack = (r != 0 && r != 1);
      cur.err = (r == 0 || r == 2);
      cur.rty = (r == 1);
      tick();
      cur.ack = 0; cur.err = 0; cur.rty = 0;
      a = next_beat(a, bte);
    end
    idle_tick();
  endtask

  initial begin
    cur = '0;
    apply_bus();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Classic write to 0x100 with two wait states.
    idle_tick();
    cur.we = 1; cur.dat = 32'hDEAD_BEEF; cur.sel = 4'hF;
    bus_beat(32'h100, 3'b000, 2'b00, 2);
    idle_tick();
    check_eq("classic_txn",  chk_txn_cnt,      1);
    check_eq("classic_beat", chk_beat_cnt,     1);
    check_eq("classic_ecnt", 32'(chk_err_cnt), 0);

    // Wrap-4 burst from 0x1C, correct and with a bad second address.
    do_reset();
    idle_tick();
    run_burst(32'h10);
    check_eq("wrap_err",  32'(chk_err), 0);
    check_eq("wrap_beat", chk_beat_cnt, 4);
    do_reset();
    idle_tick();
    run_burst(32'h20);

    // Address moves under a waiting strobe, then ack and err together.
    do_reset();
    idle_tick();
    cur.cyc = 1; cur.stb = 1; cur.adr = 32'h40;
    tick();
    cur.adr = 32'h44;
    tick();
    cur.ack = 1; cur.err = 1;
    tick();
    idle_tick();
    check_eq("unstable_code", 32'(chk_code),    4);
    check_eq("unstable_ecnt", 32'(chk_err_cnt), 2);

    // Strobe left unanswered past the timeout.
    do_reset();
    idle_tick();
    cur.cyc = 1; cur.stb = 1; cur.adr = 32'h80;
    repeat (10) tick();
    check_eq("tmo_code", 32'(chk_code),    tmo_en ? 7 : 0);
    check_eq("tmo_ecnt", 32'(chk_err_cnt), tmo_en ? 1 : 0);
    cur.ack = 1;
    tick();
    idle_tick();

    // Reset in the middle of beat 2 of a burst, then a clean classic read.
    do_reset();
    idle_tick();
    bus_beat(32'h200, 3'b010, 2'b00, 0);
    cur.adr = 32'h204;
    tick();
    do_reset();
    idle_tick();
    cur.we = 0;
    bus_beat(32'h300, 3'b000, 2'b00, 1);
    idle_tick();
    check_eq("post_rst_txn", chk_txn_cnt,  1);
    check_eq("post_rst_err", 32'(chk_err), 0);

    // Randomized traffic with occasional protocol faults.
    do_reset();
    repeat (150) rand_txn();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
